// File: rtl/contador_bcd_param.sv
// rtl/contador_bcd_param.sv - parametrised up/down BCD counter with load, limit and auto-reload
// Optional wrap-around at the limits is enabled by defining CONTADOR_BCD_WRAP_EN.
module contador_bcd_param #(
  parameter int DIGITOS     = 2,
  parameter int MAXIMO      = 99,
  parameter int LIMIAR      = 5,
  parameter int VALOR_REPOR = 25
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 habilita,
  input  logic                 i,
  input  logic                 carrega,
  input  logic [4*DIGITOS-1:0] valor_carga,
  input  logic                 auto_repor,
  output logic [4*DIGITOS-1:0] contagem,
  output logic                 no_maximo,
  output logic                 no_minimo,
  output logic                 repor_pulso
);

  localparam int W = 4 * DIGITOS;

  function automatic logic [W-1:0] to_bcd(input int valor);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = valor;
    for (int k = 0; k < DIGITOS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  localparam logic [W-1:0] MAX_BCD   = to_bcd(MAXIMO);
  localparam logic [W-1:0] REPOR_BCD = to_bcd(VALOR_REPOR);
  localparam logic [W-1:0] LIM_BCD   = to_bcd(LIMIAR);
  // A threshold beyond the representable range means every count is below it.
  localparam bit           LIM_TUDO  = (LIMIAR > pow10(DIGITOS) - 1);

`ifdef CONTADOR_BCD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [W-1:0] r_contagem;
  logic         r_repor;

  logic [W-1:0] w_inc;
  logic [W-1:0] w_dec;
  logic [W-1:0] w_sat;
  logic [W-1:0] w_carga_lim;
  logic [W-1:0] w_prox;
  logic         w_carry;
  logic         w_borrow;
  logic         w_reload;
  logic         w_abaixo;
  logic         w_no_max;
  logic         w_no_min;

  assign w_no_max = (r_contagem == MAX_BCD);
  assign w_no_min = (r_contagem == '0);
  assign w_abaixo = LIM_TUDO || (r_contagem < LIM_BCD);

  // Ripple carry/borrow across digits; every digit stays within 0..9.
  always_comb begin
    w_inc    = r_contagem;
    w_dec    = r_contagem;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    for (int k = 0; k < DIGITOS; k++) begin
      if (w_carry) begin
        if (r_contagem[4*k +: 4] >= 4'd9) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = r_contagem[4*k +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_contagem[4*k +: 4] == 4'd0) begin
          w_dec[4*k +: 4] = 4'd9;
        end else begin
          w_dec[4*k +: 4] = r_contagem[4*k +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sat = valor_carga;
    for (int k = 0; k < DIGITOS; k++) begin
      if (valor_carga[4*k +: 4] > 4'd9) w_sat[4*k +: 4] = 4'd9;
    end
    w_carga_lim = (w_sat > MAX_BCD) ? MAX_BCD : w_sat;
  end

  always_comb begin
    w_prox   = r_contagem;
    w_reload = 1'b0;
    if (carrega) begin
      w_prox = w_carga_lim;
    end else if (auto_repor && habilita && w_abaixo) begin
      w_prox   = REPOR_BCD;
      w_reload = 1'b1;
    end else if (habilita) begin
      if (i) begin
        if (w_no_max) w_prox = WRAP ? '0 : r_contagem;
        else          w_prox = w_inc;
      end else begin
        if (w_no_min) w_prox = WRAP ? MAX_BCD : r_contagem;
        else          w_prox = w_dec;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contagem <= '0;
      r_repor    <= 1'b0;
    end else begin
      r_contagem <= w_prox;
      r_repor    <= w_reload;
    end
  end

  assign contagem    = r_contagem;
  assign no_maximo   = w_no_max;
  assign no_minimo   = w_no_min;
  assign repor_pulso = r_repor;

endmodule

// File: tb/tb_contador_bcd_param.sv
// tb/tb_contador_bcd_param.sv - self-checking bench for contador_bcd_param
// Expectations follow CONTADOR_BCD_WRAP_EN when it is defined.
module tb_contador_bcd_param;

`ifdef CONTADOR_BCD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic       i;
  logic       carrega;
  logic [7:0] valor_carga;
  logic       auto_repor;
  logic [7:0] contagem;
  logic       no_maximo;
  logic       no_minimo;
  logic       repor_pulso;
  logic [7:0] contagem50;
  logic       no_maximo50;
  logic       no_minimo50;
  logic       repor_pulso50;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  contador_bcd_param u_dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .i           (i),
    .carrega     (carrega),
    .valor_carga (valor_carga),
    .auto_repor  (auto_repor),
    .contagem    (contagem),
    .no_maximo   (no_maximo),
    .no_minimo   (no_minimo),
    .repor_pulso (repor_pulso)
  );

  contador_bcd_param #(.MAXIMO(50)) u_dut50 (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .i           (i),
    .carrega     (carrega),
    .valor_carga (valor_carga),
    .auto_repor  (auto_repor),
    .contagem    (contagem50),
    .no_maximo   (no_maximo50),
    .no_minimo   (no_minimo50),
    .repor_pulso (repor_pulso50)
  );

  typedef struct {
    logic       ld;
    logic [7:0] val;
    logic       en;
    logic       up;
    logic       ar;
    logic [7:0] exp;
    logic       pl;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       mx;
    logic       mn;
    logic       pl;
  } exp_t;

  vec_t tabela[$];
  exp_t sb[$];

  function automatic vec_t mk(logic ld, logic [7:0] val, logic en, logic up,
                              logic ar, logic [7:0] exp, logic pl);
    vec_t v;
    v.ld = ld; v.val = val; v.en = en; v.up = up; v.ar = ar; v.exp = exp; v.pl = pl;
    return v;
  endfunction

  task automatic check(string nome, logic [7:0] got, logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nome, got, want);
    end
  endtask

  task automatic aplica(vec_t v, int idx);
    exp_t e;
    carrega     = v.ld;
    valor_carga = v.val;
    habilita    = v.en;
    i           = v.up;
    auto_repor  = v.ar;
    e.cnt = v.exp;
    e.mx  = (v.exp == 8'h99);
    e.mn  = (v.exp == 8'h00);
    e.pl  = v.pl;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty vec=%0d got=none want=entry", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("contagem[%0d]", idx), contagem, e.cnt);
      check($sformatf("no_maximo[%0d]", idx), {7'd0, no_maximo}, {7'd0, e.mx});
      check($sformatf("no_minimo[%0d]", idx), {7'd0, no_minimo}, {7'd0, e.mn});
      check($sformatf("repor_pulso[%0d]", idx), {7'd0, repor_pulso}, {7'd0, e.pl});
    end
  endtask

  initial begin
    reset = 1'b1; habilita = 1'b0; i = 1'b0; carrega = 1'b0;
    valor_carga = 8'h00; auto_repor = 1'b0;

    // count up 00..12 across the 09->10 digit carry
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h01, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h02, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h03, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h04, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h05, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h06, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h07, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h08, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h09, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h10, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h11, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, 8'h12, 0));
    // hold, then load 12 and count down through the borrow
    tabela.push_back(mk(0, 8'h00, 0, 1, 0, 8'h12, 0));
    tabela.push_back(mk(1, 8'h12, 0, 0, 0, 8'h12, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 0, 8'h11, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 0, 8'h10, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 0, 8'h09, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 0, 8'h08, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 0, 8'h07, 0));
    tabela.push_back(mk(1, 8'h90, 0, 0, 0, 8'h90, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 0, 8'h89, 0));
    // limits
    tabela.push_back(mk(1, 8'h99, 1, 1, 0, 8'h99, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 0, WRAP ? 8'h00 : 8'h99, 0));
    tabela.push_back(mk(1, 8'h00, 1, 0, 0, 8'h00, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 0, WRAP ? 8'h99 : 8'h00, 0));
    tabela.push_back(mk(1, 8'h98, 1, 1, 0, 8'h98, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 1, 8'h99, 0));
    // auto-reload and its one-cycle pulse
    tabela.push_back(mk(1, 8'h01, 0, 1, 0, 8'h01, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 1, 8'h25, 1));
    tabela.push_back(mk(0, 8'h00, 0, 1, 1, 8'h25, 0));
    tabela.push_back(mk(1, 8'h01, 0, 1, 0, 8'h01, 0));
    tabela.push_back(mk(0, 8'h00, 0, 1, 1, 8'h01, 0));
    tabela.push_back(mk(1, 8'h05, 0, 1, 0, 8'h05, 0));
    tabela.push_back(mk(0, 8'h00, 1, 1, 1, 8'h06, 0));
    tabela.push_back(mk(1, 8'h04, 0, 0, 0, 8'h04, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 1, 8'h25, 1));
    tabela.push_back(mk(0, 8'h00, 1, 0, 1, 8'h24, 0));
    tabela.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0));
    tabela.push_back(mk(0, 8'h00, 1, 0, 1, 8'h25, 1));
    // load sanitising and load-over-reload priority
    tabela.push_back(mk(1, 8'hA7, 0, 1, 0, 8'h97, 0));
    tabela.push_back(mk(1, 8'hFF, 0, 1, 0, 8'h99, 0));
    tabela.push_back(mk(1, 8'h5C, 0, 1, 0, 8'h59, 0));
    tabela.push_back(mk(1, 8'h02, 0, 1, 0, 8'h02, 0));
    tabela.push_back(mk(1, 8'h37, 1, 1, 1, 8'h37, 0));

    @(negedge clock);
    @(negedge clock);
    check("reset_contagem", contagem, 8'h00);
    check("reset_no_minimo", {7'd0, no_minimo}, 8'd1);
    check("reset_no_maximo", {7'd0, no_maximo}, 8'd0);
    check("reset_repor_pulso", {7'd0, repor_pulso}, 8'd0);
    reset = 1'b0;

    for (int k = 0; k < tabela.size(); k++) aplica(tabela[k], k);

    // asynchronous reset between edges at count 37
    carrega = 1'b0; habilita = 1'b0; auto_repor = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_contagem", contagem, 8'h00);
    check("async_reset_no_minimo", {7'd0, no_minimo}, 8'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("after_reset_hold", contagem, 8'h00);

    // smaller upper limit clamps loads
    carrega = 1'b1; valor_carga = 8'h73;
    @(posedge clock);
    @(negedge clock);
    check("max50_load73", contagem50, 8'h50);
    check("max50_no_maximo", {7'd0, no_maximo50}, 8'd1);
    check("max99_load73", contagem, 8'h73);
    valor_carga = 8'h42;
    @(posedge clock);
    @(negedge clock);
    check("max50_load42", contagem50, 8'h42);
    carrega = 1'b0; habilita = 1'b1; i = 1'b1;
    for (int k = 0; k < 9; k++) @(posedge clock);
    @(negedge clock);
    check("max50_count_limit", contagem50, WRAP ? 8'h00 : 8'h50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/contador_bcd_param.md
Name: contador_bcd_param

Overview:
- Parametrised synchronous up/down BCD counter with DIGITOS decimal digits, a programmable upper limit, parallel load and threshold-triggered auto-reload.
- Successor to the fixed two-digit 0–99 counter. Generalised in digit count, limit and reload values.
- Adds enable, parallel load, terminal-count flags and an optional wrap mode.
- Drives the 7-segment display decoders and the timer control logic of the design.

Parameters:
- DIGITOS, 2, number of BCD digits; count width is 4*DIGITOS bits.
- MAXIMO, 99, upper count limit as a decimal integer; must be ≤ 10^DIGITOS − 1.
- LIMIAR, 5, auto-reload threshold as a decimal integer; reload fires while count < LIMIAR.
- VALOR_REPOR, 25, auto-reload value as a decimal integer; must be ≤ MAXIMO.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous active-high reset.
- habilita  input  1  count enable; 0 holds the count. Does not block carrega.
- i  input  1  direction: 1 = increment, 0 = decrement.
- carrega  input  1  synchronous parallel load.
- valor_carga  input  4*DIGITOS  BCD load value; digit 0 in bits [3:0], the least significant digit.
- auto_repor  input  1  enables auto-reload.
- contagem  output  4*DIGITOS  current BCD count, registered.
- no_maximo  output  1  high while contagem == MAXIMO; combinational from the register.
- no_minimo  output  1  high while contagem == 0; combinational from the register.
- repor_pulso  output  1  registered one-cycle pulse on the cycle after an auto-reload.

Behaviour:
- Single clock domain; all state updates on the rising edge of clock. No gated or derived clocks; the digit-to-digit carry/borrow is combinational.
- reset=1 clears state immediately, independent of clock:
  - contagem=0, repor_pulso=0.
  - Flags: no_minimo=1, no_maximo=0 (no_maximo=1 only if MAXIMO=0).
- Reset release is taken into account at the next rising edge.
- Priority per edge, highest first: reset > carrega > auto-reload > count > hold.
- Load (carrega=1):
  - contagem ← valor_carga.
  - Any digit >9 is replaced by 9 before the compare.
  - The resulting value is clamped to MAXIMO if greater.
- Auto-reload: applies when carrega=0, auto_repor=1, habilita=1 and contagem < LIMIAR (compare uses the current register value).
  - contagem ← VALOR_REPOR.
  - repor_pulso=1 for exactly the next cycle.
  - Takes precedence over counting.
- Count (habilita=1, no load, no reload):
  - i=1: BCD +1. A digit at 9 rolls to 0 and carries into the next digit.
  - i=0: BCD −1. A digit at 0 rolls to 9 and borrows from the next digit.
- Boundaries without wrap (default):
  - i=1 at MAXIMO holds.
  - i=0 at 0 holds.
  - No invalid BCD value is ever produced.
- repor_pulso is 0 on every cycle not directly following a reload.
- A direction change takes effect at the very next enabled edge; no pipeline latency.
- Parameters are converted to BCD at elaboration; no runtime binary-to-BCD conversion.

Optional Feature:
- Macro CONTADOR_BCD_WRAP_EN.
- When defined:
  - i=1 at MAXIMO → contagem=0 next edge.
  - i=0 at 0 → contagem=MAXIMO next edge.
  - Auto-reload still has priority over wrap.
- When undefined: saturating behaviour as specified in Behaviour.

Test Plan (defaults DIGITOS=2, MAXIMO=99, LIMIAR=5, VALOR_REPOR=25 unless noted):
1. Reset, then i=1, habilita=1 for 12 edges → contagem steps 00..12; at 09→10 the units digit goes to 0 and the tens digit goes to 1.
2. Load 12, then i=0 for 4 edges → 11, 10, 09, 08. Then one more edge with auto_repor=0 → 07.
3. Load 99 with i=1 → holds at 99 and no_maximo=1. With CONTADOR_BCD_WRAP_EN, one edge → 00. Separately, at 00 with i=0 → holds at 00 (no_minimo=1); with wrap, one edge → 99.
4. Count at 01 with auto_repor=1 on an edge → contagem=25 and repor_pulso=1 for one cycle. With habilita=0 the same edge → stays 01, no pulse.
5. Load valor_carga=8'hA7 → contagem=97. With MAXIMO=50, load 8'h73 → 50 and no_maximo=1.
6. Assert reset asynchronously between edges at count 37 → contagem=00 immediately. Simultaneous carrega=1 and auto_repor=1 at count 02 → the load value wins and repor_pulso=0.
